cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 register file for the P7 MIPS pipeline. It consumes the M-stage exception code produced by the exception pipeline, together with the external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId. Serves mfc0/mtc0 in the M stage.
- Decides when to take an interrupt or exception (IntReq) and supplies the EPC value used by eret.

Parameters:
- PRID, 32'h2023_0707, constant value returned when reading PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  mtc0 write enable (M stage).
- addr  in  5  CP0 register number for read and write.
- wdata  in  32  mtc0 write data.
- rdata  out  32  mfc0 read data, combinational.
- pc_m  in  32  PC of the instruction currently in M.
- bd_m  in  1  M instruction sits in a branch delay slot.
- exc_code_m  in  5  exception code from M; 0 means none.
- hw_int  in  6  external interrupt lines, level-sensitive.
- eret_m  in  1  eret in M.
- int_req  out  1  take exception or interrupt this cycle; flushes the pipeline.
- epc_out  out  32  EPC value for eret, with forwarding.
- handler_pc  out  32  always equals HANDLER_PC.

Behaviour:
- Register layout:
  - SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
  - Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
  - Unimplemented bits read 0.
- Reset: SR, Cause and EPC all clear to 0 asynchronously on rst_n=0. Outputs follow from that state: int_req=0, epc_out=0, rdata=PRID only when addr=15. Reset mid-exception discards the in-flight capture.
- IP tracking: Cause.IP <= hw_int every cycle, regardless of other events.
- Combinational request terms:
  - irq = |(hw_int & IM) & IE & ~EXL.
  - exc = (exc_code_m != 0) & ~EXL.
  - int_req = irq | exc.
- Capture on the edge where int_req=1:
  - EXL <= 1.
  - ExcCode <= irq ? 0 : exc_code_m. Interrupt beats exception when both occur.
  - BD <= bd_m.
  - EPC <= bd_m ? pc_m-4 : pc_m, with bits [1:0] forced to 0.
- Precedence on a cycle with int_req=1: any mtc0 (we) and any eret_m are ignored, because the M instruction is squashed.
- eret without int_req: EXL <= 0 on the next edge.
- mtc0 writes, when int_req=0:
  - addr 12 writes IM and EXL/IE only.
  - addr 14 writes EPC[31:2], with [1:0] forced to 0.
  - Writes to 13, 15 or any other address are ignored.
  - mtc0 and eret in the same cycle cannot occur (one M instruction); if both are asserted, the write applies and EXL clears.
- Read latency:
  - rdata is combinational from current state: 12→SR, 13→Cause, 14→EPC, 15→PRID, else 0.
  - A write becomes visible on the following cycle.
- epc_out: equals wdata[31:2]<<2 when we & addr==14, otherwise EPC. This forwards an mtc0-then-eret pair.
- Nesting: while EXL=1, no new capture occurs, even if exc_code_m is nonzero.

Optional Feature:
- Macro: CP0_BADVADDR_EN.
- Defined: adds BadVAddr (reg 8) and input bad_addr_m[31:0].
  - On capture with exc_code_m=4 or 5 (not interrupt), BadVAddr <= bad_addr_m; otherwise it holds.
  - Resets to 0; read-only to mtc0.
- Undefined: no port, and reg 8 reads 0.

Decomposition:
- Shared package/header holds:
  - Register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_BADVADDR=8.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause bit positions.
- No sub-module; a single flat module.

Test Plan:
- Reset with rst_n=0 mid-cycle → SR=Cause=EPC=0 immediately; int_req=0; read addr 15 → 32'h2023_0707.
- mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 → int_req=1 same cycle; next cycle Cause.ExcCode=0, EXL=1, EPC=pc_m (e.g. 32'h0000_3010).
- exc_code_m=12, bd_m=1, pc_m=32'h0000_3024, EXL=0 → int_req=1; EPC=32'h0000_3020, Cause=32'h8000_0030.
- EXL=1 with exc_code_m=10 → int_req=0 and EPC unchanged; then eret_m=1 → EXL=0 next cycle.
- mtc0 EPC=32'h0000_3403 with eret_m in the same cycle → epc_out=32'h0000_3400 that cycle; EPC reads 32'h0000_3400 after.
- Simultaneous hw_int (enabled) and exc_code_m=4 plus we to SR → ExcCode=0 (interrupt wins), SR write dropped; with CP0_BADVADDR_EN, BadVAddr is unchanged.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 register numbers, exception codes and SR/Cause bit positions.
// Used by cp0_unit (optional BadVAddr register enabled by CP0_BADVADDR_EN).
package cp0_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int unsigned SR_IE       = 0;
    localparam int unsigned SR_EXL      = 1;
    localparam int unsigned SR_IM_LO    = 10;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_BD     = 31;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] v;
        v = '0;
        v[SR_IM_LO +: 6] = im;
        v[SR_EXL]        = exl;
        v[SR_IE]         = ie;
        return v;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD]              = bd;
        v[CAUSE_IP_LO +: 6]      = ip;
        v[CAUSE_EXC_LO +: 5]     = exc;
        return v;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file: SR, Cause, EPC, PRId, interrupt/exception capture.
// Define CP0_BADVADDR_EN to add the BadVAddr register (reg 8) and the i_bad_addr_m port.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h2023_0707,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_pc_m,
    input  logic        i_bd_m,
    input  logic [4:0]  i_exc_code_m,
    input  logic [5:0]  i_hw_int,
    input  logic        i_eret_m,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] i_bad_addr_m,
`endif
    output logic        o_int_req,
    output logic [31:0] o_epc_out,
    output logic [31:0] o_handler_pc
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [29:0] r_epc;
`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;
`endif

    logic        w_irq;
    logic        w_exc;
    logic        w_int_req;
    logic [29:0] w_epc_cap;
    logic        w_epc_wr;
    logic        w_unused;

    assign w_irq     = (|(i_hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc     = (i_exc_code_m != 5'd0) & ~r_exl;
    assign w_int_req = w_irq | w_exc;
    // Word-aligned PC; pc-4 on the word index is just a decrement.
    assign w_epc_cap = i_bd_m ? (i_pc_m[31:2] - 30'd1) : i_pc_m[31:2];
    assign w_epc_wr  = i_we & (i_addr == CP0_EPC);
    assign w_unused  = ^{i_pc_m[1:0], i_wdata[31:16], i_wdata[9:2]};

    assign o_int_req    = w_int_req;
    assign o_epc_out    = w_epc_wr ? {i_wdata[31:2], 2'b00} : {r_epc, 2'b00};
    assign o_handler_pc = HANDLER_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
`ifdef CP0_BADVADDR_EN
            r_badvaddr <= '0;
`endif
        end else begin
            r_ip <= i_hw_int;
            if (w_int_req) begin
                // The M instruction is squashed, so its mtc0/eret never take effect.
                r_exl      <= 1'b1;
                r_exc_code <= w_irq ? EXC_INT : i_exc_code_m;
                r_bd       <= i_bd_m;
                r_epc      <= w_epc_cap;
`ifdef CP0_BADVADDR_EN
                if (!w_irq && (i_exc_code_m == EXC_ADEL || i_exc_code_m == EXC_ADES)) begin
                    r_badvaddr <= i_bad_addr_m;
                end
`endif
            end else begin
                if (i_we) begin
                    case (i_addr)
                        CP0_SR: begin
                            r_im  <= i_wdata[SR_IM_LO +: 6];
                            r_exl <= i_wdata[SR_EXL];
                            r_ie  <= i_wdata[SR_IE];
                        end
                        CP0_EPC: r_epc <= i_wdata[31:2];
                        default: ;
                    endcase
                end
                if (i_eret_m) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            CP0_SR:    o_rdata = pack_sr(r_im, r_exl, r_ie);
            CP0_CAUSE: o_rdata = pack_cause(r_bd, r_ip, r_exc_code);
            CP0_EPC:   o_rdata = {r_epc, 2'b00};
            CP0_PRID:  o_rdata = PRID;
`ifdef CP0_BADVADDR_EN
            CP0_BADVADDR: o_rdata = r_badvaddr;
`endif
            default:   o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (optionally with CP0_BADVADDR_EN).
module tb_cp0_unit;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
`ifdef CP0_BADVADDR_EN
    logic [31:0] bad_addr_m;
`endif

    int n_total;
    int n_pass;

    cp0_unit u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_we         (we),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .i_pc_m       (pc_m),
        .i_bd_m       (bd_m),
        .i_exc_code_m (exc_code_m),
        .i_hw_int     (hw_int),
        .i_eret_m     (eret_m),
`ifdef CP0_BADVADDR_EN
        .i_bad_addr_m (bad_addr_m),
`endif
        .o_int_req    (int_req),
        .o_epc_out    (epc_out),
        .o_handler_pc (handler_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0; we = 1'b0; addr = 5'd0; wdata = '0; pc_m = '0; bd_m = 1'b0;
        exc_code_m = '0; hw_int = '0; eret_m = 1'b0;
`ifdef CP0_BADVADDR_EN
        bad_addr_m = '0;
`endif
        #1;
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_epc_out", epc_out, 32'd0);
        check("handler_pc", handler_pc, 32'h0000_4180);
        rd("rst_prid", 5'd15, 32'h2023_0707);
        rd("rst_sr", 5'd12, 32'd0);
        #11 rst_n = 1'b1;
        step();

        // Enable all interrupt lines with IE=1.
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
        step();
        we = 1'b0;
        rd("sr_written", 5'd12, 32'h0000_FC01);
        check("no_req_idle", {31'd0, int_req}, 32'd0);

        hw_int = 6'b000100; pc_m = 32'h0000_3010;
        #1;
        check("irq_req", {31'd0, int_req}, 32'd1);
        step();
        hw_int = 6'b000000;
        rd("irq_cause", 5'd13, 32'h0000_1000);
        rd("irq_sr_exl", 5'd12, 32'h0000_FC03);
        rd("irq_epc", 5'd14, 32'h0000_3010);
        check("irq_epc_out", epc_out, 32'h0000_3010);

        eret_m = 1'b1;
        step();
        eret_m = 1'b0;
        rd("eret1_sr", 5'd12, 32'h0000_FC01);

        // Overflow in a delay slot.
        exc_code_m = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3024;
        #1;
        check("ov_req", {31'd0, int_req}, 32'd1);
        step();
        exc_code_m = 5'd0; bd_m = 1'b0;
        rd("ov_epc", 5'd14, 32'h0000_3020);
        rd("ov_cause", 5'd13, 32'h8000_0030);

        // Nested exception while EXL=1 is not taken.
        exc_code_m = 5'd10; pc_m = 32'h0000_3028;
        #1;
        check("nest_no_req", {31'd0, int_req}, 32'd0);
        step();
        exc_code_m = 5'd0;
        rd("nest_epc", 5'd14, 32'h0000_3020);
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;
        rd("eret2_sr", 5'd12, 32'h0000_FC01);

        // mtc0 EPC forwarded to eret in the same cycle.
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_3403; eret_m = 1'b1;
        #1;
        check("fwd_epc_out", epc_out, 32'h0000_3400);
        step();
        we = 1'b0; eret_m = 1'b0;
        rd("fwd_epc", 5'd14, 32'h0000_3400);
        rd("fwd_sr", 5'd12, 32'h0000_FC01);

        // Writes to Cause and PRId are ignored.
        we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        step();
        addr = 5'd15;
        step();
        we = 1'b0;
        rd("cause_ro", 5'd13, 32'h8000_0030);
        rd("prid_ro", 5'd15, 32'h2023_0707);
        rd("reg8", 5'd8, 32'd0);
        rd("reg_other", 5'd3, 32'd0);

        // Interrupt and AdEL together with an SR write: interrupt wins, write dropped.
        hw_int = 6'b000001; exc_code_m = 5'd4; we = 1'b1; addr = 5'd12; wdata = 32'd0;
        pc_m = 32'h0000_3100;
`ifdef CP0_BADVADDR_EN
        bad_addr_m = 32'hDEAD_BEEF;
`endif
        #1;
        check("both_req", {31'd0, int_req}, 32'd1);
        step();
        we = 1'b0; exc_code_m = 5'd0;
        rd("both_cause", 5'd13, 32'h0000_0400);
        rd("both_sr", 5'd12, 32'h0000_FC03);
        rd("both_epc", 5'd14, 32'h0000_3100);
`ifdef CP0_BADVADDR_EN
        rd("both_badv", 5'd8, 32'd0);
`endif
        hw_int = 6'b000000; eret_m = 1'b1;
        step();
        eret_m = 1'b0;
`ifdef CP0_BADVADDR_EN
        exc_code_m = 5'd5; bad_addr_m = 32'h1234_5678;
        step();
        exc_code_m = 5'd0;
        rd("ades_badv", 5'd8, 32'h1234_5678);
        eret_m = 1'b1;
        step();
        eret_m = 1'b0;
`endif

        // Masked line does not request.
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        step();
        we = 1'b0;
        hw_int = 6'b000010;
        #1;
        check("masked_no_req", {31'd0, int_req}, 32'd0);
        hw_int = 6'b000011;
        #1;
        check("unmasked_req", {31'd0, int_req}, 32'd1);
        step();

        // Asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        check("arst_int_req", {31'd0, int_req}, 32'd0);
        check("arst_epc_out", epc_out, 32'd0);
        rd("arst_sr", 5'd12, 32'd0);
        rd("arst_cause", 5'd13, 32'd0);
        rd("arst_epc", 5'd14, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
